ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction-fetch stage of the five-stage RISC-V pipeline. It produces the IF/ID pipeline register (`Instruction_id`, `PC_id`) that the decode stage consumes, and it obeys the decode stage's `IFWrite`, `Branch`, `Jump` and `JumpAddr` controls. It keeps the fetch PC and issues single-outstanding requests to instruction memory, which may have variable latency. It buffers one returned instruction while decode is stalled and discards wrong-path responses after a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset.
- `NOP_INSN`, default 32'h0000_0013, bubble instruction (`addi x0,x0,0`).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `IFWrite` input 1: from decode; 0 means decode is stalled and the IF/ID register must hold.
- `Branch` input 1: from decode; taken branch for the instruction in IF/ID.
- `Jump` input 1: from decode; JAL/JALR for the instruction in IF/ID.
- `JumpAddr` input 32: redirect target. Valid when `Branch` or `Jump` is 1.
- `imem_req` output 1: fetch request. Held at 1 until acknowledged.
- `imem_addr` output 32: fetch address. Stable while `imem_req` is 1.
- `imem_ack` input 1: response valid. Ignored when `imem_req` is 0.
- `imem_rdata` input 32: instruction word. Valid with `imem_ack`.
- `Instruction_id` output 32: IF/ID instruction.
- `PC_id` output 32: IF/ID PC.
- `Valid_id` output 1: 1 means the IF/ID contents are a real instruction; 0 means a bubble.

## Operation
- Redirect is effective only when `IFWrite & (Branch | Jump)`. When `IFWrite` is 0, `Branch` and `Jump` are ignored, so stall has priority.
- Internal state:
  - `pc_q`: the fetch PC.
  - `buf_q`: a one-entry instruction buffer.
  - `redir_q`: the pending redirect target.
  - A three-state FSM: REQ, HOLD, DROP.
- REQ state: `imem_req`=1, `imem_addr`=`pc_q`.
  - ack and redirect: IF/ID <= bubble; `pc_q` <= `JumpAddr`; stay in REQ.
  - ack, `IFWrite`=1, no redirect: IF/ID <= {`imem_rdata`, `pc_q`, valid}; `pc_q` += 4; stay in REQ.
  - ack, `IFWrite`=0: `buf_q` <= `imem_rdata`; go to HOLD. IF/ID holds.
  - no ack and redirect: `redir_q` <= `JumpAddr`; IF/ID <= bubble; go to DROP.
  - no ack, `IFWrite`=1: IF/ID <= bubble.
  - no ack, `IFWrite`=0: IF/ID holds.
- HOLD state: `imem_req`=0.
  - redirect: discard `buf_q`; IF/ID <= bubble; `pc_q` <= `JumpAddr`; go to REQ.
  - `IFWrite`=1: IF/ID <= {`buf_q`, `pc_q`, valid}; `pc_q` += 4; go to REQ.
  - otherwise: stay in HOLD.
- DROP state: `imem_req`=1, `imem_addr`=`pc_q` (the stale address is held to honour the protocol).
  - ack: drop the data; `pc_q` <= `redir_q`; go to REQ.
  - A new redirect while in DROP overwrites `redir_q`.
  - IF/ID <= bubble whenever `IFWrite` is 1.
- Bubble: `Instruction_id`=`NOP_INSN`, `Valid_id`=0, `PC_id` keeps its previous value.
- PC arithmetic is 32-bit modulo: 0xFFFF_FFFC + 4 wraps to 0. `JumpAddr` is used as given; no alignment check.

## Timing
- Reset values:
  - state=REQ, `pc_q`=`RESET_PC`.
  - `imem_req`=0 while `rst_n`=0. It rises in the first cycle after release.
  - `Instruction_id`=`NOP_INSN`, `PC_id`=0, `Valid_id`=0.
- `imem_ack` may arrive in the same cycle `imem_req` rises, so combinational memory works. In that case there is one instruction per cycle with no stalls.
- Fetch-to-ID latency is 1 clock after the ack edge.
- Redirect penalty is one bubble with zero-latency memory, more otherwise.
- Reset mid-request: the outstanding request is abandoned. Memory must drop it when it sees `imem_req` fall.
- All outputs are registered, except `imem_req` and `imem_addr`, which are decoded from the registered state and `pc_q`.

## Structure
- Shared package `cpu_pkg`:
  - `NOP_INSN` constant.
  - `RESET_PC` default.
  - The fetch-state enum.
- Optional sub-module `ifid_reg`: the IF/ID register with load/bubble/hold control. Everything else stays inline.

## Test plan
- Zero-latency memory returning `addr^32'hA5A5_0000`, `IFWrite`=1 -> after reset, `PC_id` = 0, 4, 8 on consecutive cycles, all with `Valid_id`=1.
- 3-cycle ack latency -> two bubbles, then PC 0; `imem_addr` stable during each wait.
- Ack at PC 8 with `IFWrite`=0 for 4 cycles -> state HOLD, `imem_req`=0, IF/ID unchanged. After `IFWrite`=1, `PC_id`=8 with the buffered word.
- `Jump`=1, `JumpAddr`=0x100 while the request for 0x10 is pending with 2-cycle latency -> the 0x10 data is discarded and never appears in `Instruction_id`. The next `imem_addr`=0x100, and `PC_id`=0x100 follows.
- `Branch`=1 with `IFWrite`=0 -> no redirect and `pc_q` unchanged.
- `rst_n` low mid-DROP -> immediately `imem_req`=0, `Valid_id`=0; after release, the first fetch is at `RESET_PC`.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline constants (bubble instruction, reset PC) and the fetch FSM state type
package cpu_pkg;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} fetch_state_t;
endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: instruction-memory bus; master (fetch) drives imem_req/imem_addr, slave (memory) drives imem_ack/imem_rdata
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ifetch_unit_ifid_reg.sv
// ifid_reg: IF/ID register; load captures {insn, pc, valid}, bubble inserts NOP with Valid_id=0 keeping PC_id, else holds
module ifid_reg #(
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] insn,
  input  logic [31:0] pc,
  output logic [31:0] Instruction_id,
  output logic [31:0] PC_id,
  output logic        Valid_id
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      Instruction_id <= NOP_INSN;
      PC_id          <= '0;
      Valid_id       <= 1'b0;
    end else if (load) begin
      Instruction_id <= insn;
      PC_id          <= pc;
      Valid_id       <= 1'b1;
    end else if (bubble) begin
      Instruction_id <= NOP_INSN;
      Valid_id       <= 1'b0;
    end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch stage; ports clk/rst_n, decode controls IFWrite/Branch/Jump/JumpAddr, imem master bus, IF/ID outputs Instruction_id/PC_id/Valid_id
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSN = cpu_pkg::NOP_INSN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               IFWrite,
  input  logic               Branch,
  input  logic               Jump,
  input  logic [31:0]        JumpAddr,
  ifetch_unit_if.master      imem,
  output logic [31:0]        Instruction_id,
  output logic [31:0]        PC_id,
  output logic               Valid_id
);
  import cpu_pkg::*;
  fetch_state_t state, nxt;
  logic [31:0] pc_q, pc_d, buf_q, buf_d, redir_q, redir_d, ld_insn;
  logic req_en, ack, redir, load, bubble;
  // req_en keeps imem_req low through reset and rises on the first edge after release
  assign imem.imem_req  = req_en & (state != S_HOLD);
  assign imem.imem_addr = pc_q;
  assign ack            = imem.imem_ack & imem.imem_req;
  assign redir          = IFWrite & (Branch | Jump);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= S_REQ;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INSN;
      redir_q <= RESET_PC;
      req_en  <= 1'b0;
    end else begin
      state   <= nxt;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      redir_q <= redir_d;
      req_en  <= 1'b1;
    end
  always_comb begin
    nxt     = state;
    pc_d    = pc_q;
    buf_d   = buf_q;
    redir_d = redir_q;
    ld_insn = imem.imem_rdata;
    load    = 1'b0;
    bubble  = 1'b0;
    case (state)
      S_REQ: begin
        load    = ack & IFWrite & !redir;
        bubble  = redir | (!ack & IFWrite);
        pc_d    = (ack & redir) ? JumpAddr : load ? pc_q + 32'd4 : pc_q;
        buf_d   = (ack & !IFWrite) ? imem.imem_rdata : buf_q;
        redir_d = (!ack & redir) ? JumpAddr : redir_q;
        nxt     = (ack & !IFWrite) ? S_HOLD : (!ack & redir) ? S_DROP : S_REQ;
      end
      S_HOLD: begin
        ld_insn = buf_q;
        load    = IFWrite & !redir;
        bubble  = redir;
        pc_d    = redir ? JumpAddr : load ? pc_q + 32'd4 : pc_q;
        nxt     = IFWrite ? S_REQ : S_HOLD;
      end
      default: begin
        // wrong-path response is consumed and dropped; a redirect on the same edge wins
        bubble  = IFWrite;
        redir_d = redir ? JumpAddr : redir_q;
        pc_d    = ack ? redir_d : pc_q;
        nxt     = ack ? S_REQ : S_DROP;
      end
    endcase
  end
  ifid_reg #(.NOP_INSN(NOP_INSN)) u_ifid (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (load),
    .bubble         (bubble),
    .insn           (ld_insn),
    .pc             (pc_q),
    .Instruction_id (Instruction_id),
    .PC_id          (PC_id),
    .Valid_id       (Valid_id)
  );
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed checks of ifetch_unit against a variable-latency memory returning addr^A5A5_0000
module tb_ifetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic IFWrite = 1'b1, Branch = 1'b0, Jump = 1'b0;
  logic [31:0] JumpAddr = '0;
  logic [31:0] Instruction_id, PC_id;
  logic Valid_id;
  int total = 0, bad = 0, cnt = 0, wait_n = 0;
  ifetch_unit_if imem();
  ifetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IFWrite        (IFWrite),
    .Branch         (Branch),
    .Jump           (Jump),
    .JumpAddr       (JumpAddr),
    .imem           (imem.master),
    .Instruction_id (Instruction_id),
    .PC_id          (PC_id),
    .Valid_id       (Valid_id)
  );
  always #5 clk = ~clk;
  assign imem.imem_ack   = imem.imem_req && (cnt >= wait_n);
  assign imem.imem_rdata = imem.imem_addr ^ 32'hA5A5_0000;
  always @(posedge clk) cnt <= (imem.imem_req && !imem.imem_ack) ? cnt + 1 : 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic nxt();
    @(negedge clk);
  endtask
  task automatic id(input string tag, input logic [31:0] pc, input logic [31:0] insn, input logic v);
    chk({tag, ".pc"}, PC_id, pc);
    chk({tag, ".insn"}, Instruction_id, insn);
    chk({tag, ".valid"}, {31'd0, Valid_id}, {31'd0, v});
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    nxt();
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    nxt();
    nxt();
    chk("rst.req", {31'd0, imem.imem_req}, 32'd0);
    id("rst", 32'h0, 32'h13, 1'b0);
    rst_n = 1'b1;
    nxt();
    chk("t1.req", {31'd0, imem.imem_req}, 32'd1);
    chk("t1.addr0", imem.imem_addr, 32'h0);
    nxt();
    id("t1.a", 32'h0, 32'hA5A5_0000, 1'b1);
    nxt();
    id("t1.b", 32'h4, 32'hA5A5_0004, 1'b1);
    nxt();
    id("t1.c", 32'h8, 32'hA5A5_0008, 1'b1);
    wait_n = 2;
    do_reset();
    chk("t2.addr_w0", imem.imem_addr, 32'h0);
    nxt();
    chk("t2.addr_w1", imem.imem_addr, 32'h0);
    chk("t2.bub1", {31'd0, Valid_id}, 32'd0);
    nxt();
    chk("t2.addr_w2", imem.imem_addr, 32'h0);
    chk("t2.bub2", {31'd0, Valid_id}, 32'd0);
    nxt();
    id("t2.pc0", 32'h0, 32'hA5A5_0000, 1'b1);
    chk("t2.addr4", imem.imem_addr, 32'h4);
    wait_n = 0;
    do_reset();
    nxt();
    nxt();
    id("t3.pre", 32'h4, 32'hA5A5_0004, 1'b1);
    chk("t3.addr8", imem.imem_addr, 32'h8);
    IFWrite = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("t3.hold_req", {31'd0, imem.imem_req}, 32'd0);
      id("t3.hold", 32'h4, 32'hA5A5_0004, 1'b1);
    end
    IFWrite = 1'b1;
    nxt();
    id("t3.buf", 32'h8, 32'hA5A5_0008, 1'b1);
    chk("t3.addrC", imem.imem_addr, 32'hC);
    do_reset();
    for (int i = 0; i < 4; i++) nxt();
    chk("t4.addr10", imem.imem_addr, 32'h10);
    id("t4.pre", 32'hC, 32'hA5A5_000C, 1'b1);
    wait_n = 1;
    Jump = 1'b1;
    JumpAddr = 32'h100;
    nxt();
    Jump = 1'b0;
    JumpAddr = 32'h0;
    chk("t4.drop_req", {31'd0, imem.imem_req}, 32'd1);
    chk("t4.drop_addr", imem.imem_addr, 32'h10);
    id("t4.drop", 32'hC, 32'h13, 1'b0);
    nxt();
    chk("t4.addr100", imem.imem_addr, 32'h100);
    id("t4.bub1", 32'hC, 32'h13, 1'b0);
    nxt();
    id("t4.bub2", 32'hC, 32'h13, 1'b0);
    nxt();
    id("t4.tgt", 32'h100, 32'hA5A5_0100, 1'b1);
    IFWrite = 1'b0;
    Branch = 1'b1;
    JumpAddr = 32'h200;
    nxt();
    chk("t5.addr", imem.imem_addr, 32'h104);
    id("t5.stall", 32'h100, 32'hA5A5_0100, 1'b1);
    nxt();
    chk("t5.hold_req", {31'd0, imem.imem_req}, 32'd0);
    IFWrite = 1'b1;
    Branch = 1'b0;
    nxt();
    id("t5.next", 32'h104, 32'hA5A5_0104, 1'b1);
    chk("t5.addr108", imem.imem_addr, 32'h108);
    Jump = 1'b1;
    JumpAddr = 32'h300;
    nxt();
    Jump = 1'b0;
    chk("t6.drop_addr", imem.imem_addr, 32'h108);
    chk("t6.drop_valid", {31'd0, Valid_id}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6.rst_req", {31'd0, imem.imem_req}, 32'd0);
    id("t6.rst", 32'h0, 32'h13, 1'b0);
    wait_n = 0;
    nxt();
    rst_n = 1'b1;
    nxt();
    chk("t6.req", {31'd0, imem.imem_req}, 32'd1);
    chk("t6.addr", imem.imem_addr, 32'h0);
    nxt();
    id("t6.pc0", 32'h0, 32'hA5A5_0000, 1'b1);
    Jump = 1'b1;
    JumpAddr = 32'hFFFF_FFFC;
    nxt();
    Jump = 1'b0;
    id("t7.bub", 32'h0, 32'h13, 1'b0);
    chk("t7.addr", imem.imem_addr, 32'hFFFF_FFFC);
    nxt();
    id("t7.top", 32'hFFFF_FFFC, 32'h5A5A_FFFC, 1'b1);
    chk("t7.wrap", imem.imem_addr, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
